nes_pad_responder: RTL and testbench

NES_PAD_RESPONDER -- requirements
Module: nes_pad_responder

---
 rtl/nes_pad_responder.sv | 96 +++++++++
 tb/tb_nes_pad_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_responder.sv
// NES controller emulation: debounces eight switches and answers the console's
// strobe/clock protocol with an active-low serial stream, button A first.
module nes_pad_responder #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       pad_strobe,
  input  logic       pad_clk,
  input  logic [7:0] buttons_raw,
  output logic       pad_data,
  output logic [7:0] buttons_db,
  output logic [3:0] bits_sent
);

  localparam int CW = 20;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            strobe_meta_q, strobe_sync_q;
  logic            pclk_meta_q, pclk_sync_q, pclk_prev_q;
  logic [7:0]      btn_meta_q, btn_sync_q;
  logic [7:0][CW-1:0] cnt_q, cnt_d;
  logic [7:0]      db_q, db_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [3:0]      sent_q, sent_d;
  logic            pad_data_q, pad_data_d;
  logic            pclk_rise;

  // Synchronizers idle as an unpressed pad with the shift clock parked high,
  // so leaving reset can never fabricate a shift edge.
  always_ff @(posedge clk) begin
    if (nreset) begin
      strobe_meta_q <= 1'b0;
      strobe_sync_q <= 1'b0;
      pclk_meta_q   <= 1'b1;
      pclk_sync_q   <= 1'b1;
      pclk_prev_q   <= 1'b1;
      btn_meta_q    <= 8'h00;
      btn_sync_q    <= 8'h00;
      cnt_q         <= '0;
      db_q          <= 8'h00;
      shreg_q       <= 8'h00;
      sent_q        <= 4'd0;
      pad_data_q    <= 1'b1;
    end else begin
      strobe_meta_q <= pad_strobe;
      strobe_sync_q <= strobe_meta_q;
      pclk_meta_q   <= pad_clk;
      pclk_sync_q   <= pclk_meta_q;
      pclk_prev_q   <= pclk_sync_q;
      btn_meta_q    <= buttons_raw;
      btn_sync_q    <= btn_meta_q;
      cnt_q         <= cnt_d;
      db_q          <= db_d;
      shreg_q       <= shreg_d;
      sent_q        <= sent_d;
      pad_data_q    <= pad_data_d;
    end
  end

  always_comb begin
    pclk_rise = pclk_sync_q & ~pclk_prev_q;
    cnt_d     = cnt_q;
    db_d      = db_q;
    // Any cycle agreeing with the debounced level wipes the run count.
    for (int i = 0; i < 8; i++) begin
      if (btn_sync_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = btn_sync_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    shreg_d = shreg_q;
    sent_d  = sent_q;
    if (strobe_sync_q) begin
      shreg_d = db_q;
      sent_d  = 4'd0;
    end else if (pclk_rise) begin
      shreg_d = {1'b0, shreg_q[7:1]};
      if (sent_q != 4'd8) sent_d = sent_q + 4'd1;
    end
    // Registered from the next-state value to keep pin-to-pin latency at 3.
    pad_data_d = ~shreg_d[0];
  end

  assign pad_data   = pad_data_q;
  assign buttons_db = db_q;
  assign bits_sent  = sent_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Randomized bench for nes_pad_responder: a queue-based pad model predicts
// pad_data / bits_sent / buttons_db and a negedge monitor scores the DUT.
module tb_nes_pad_responder;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       nreset;
  logic       pad_strobe;
  logic       pad_clk;
  logic [7:0] buttons_raw;
  logic       pad_data;
  logic [7:0] buttons_db;
  logic [3:0] bits_sent;

  nes_pad_responder #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .pad_strobe (pad_strobe),
    .pad_clk    (pad_clk),
    .buttons_raw(buttons_raw),
    .pad_data   (pad_data),
    .buttons_db (buttons_db),
    .bits_sent  (bits_sent)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: {pad_data, bits_sent, buttons_db}
  logic [12:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // reference model: debounced buttons plus the list of bits still to be sent
  logic [7:0]  mdl_db;
  bit          mdl_latched[$];
  int          mdl_sent;
  bit          mdl_strobe;

  function automatic logic [12:0] model_out();
    logic pd;
    pd = (mdl_latched.size() == 0) ? 1'b1 : ~mdl_latched[0];
    return {pd, 4'(mdl_sent), mdl_db};
  endfunction

  function automatic void model_reset();
    mdl_db = 8'h00;
    mdl_latched.delete();
    mdl_sent = 0;
  endfunction

  function automatic void model_load();
    mdl_latched.delete();
    for (int i = 0; i < 8; i++) mdl_latched.push_back(mdl_db[i]);
    mdl_sent = 0;
  endfunction

  function automatic void model_shift();
    if (mdl_strobe) return;
    if (mdl_latched.size() > 0) void'(mdl_latched.pop_front());
    if (mdl_sent < 8) mdl_sent++;
  endfunction

  // monitor
  logic [12:0] mon_exp, mon_act;
  string       mon_nm;
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      mon_act = {pad_data, bits_sent, buttons_db};
      n_cmp++;
      if (mon_act !== mon_exp) begin
        n_bad++;
        $display("FAIL %s: got pad_data=%b bits_sent=%0d buttons_db=%h, want pad_data=%b bits_sent=%0d buttons_db=%h",
                 mon_nm, mon_act[12], mon_act[11:8], mon_act[7:0],
                 mon_exp[12], mon_exp[11:8], mon_exp[7:0]);
      end
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_check(input string nm);
    exp_q.push_back(model_out());
    name_q.push_back(nm);
  endtask

  task automatic do_reset();
    nreset = 1'b1;
    tick(1);
    model_reset();
    push_check("reset");
    tick(1);
    push_check("reset_hold");
    nreset = 1'b0;
  endtask

  task automatic hold_buttons(input logic [7:0] v, input string nm);
    buttons_raw = v;
    tick(10);
    mdl_db = v;
    if (mdl_strobe) model_load();
    push_check(nm);
  endtask

  task automatic strobe_set(input logic lvl);
    pad_strobe = lvl;
    tick(3);
    mdl_strobe = lvl;
    if (lvl) begin
      model_load();
      push_check("load");
    end else begin
      push_check("strobe_fall");
    end
  endtask

  task automatic strobe_pulse(input int w);
    strobe_set(1'b1);
    if (w > 1) tick(w - 1);
    strobe_set(1'b0);
  endtask

  task automatic pad_clk_pulse(input int low_w, input string nm);
    pad_clk = 1'b0;
    tick(low_w);
    push_check({nm, "_fall"});
    pad_clk = 1'b1;
    tick(3);
    model_shift();
    push_check(nm);
  endtask

  task automatic glitch(input logic [7:0] mask, input int w);
    buttons_raw = mdl_db ^ mask;
    tick(w);
    buttons_raw = mdl_db;
    tick(6);
    push_check("glitch");
  endtask

  // watchdog
  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit, got no summary, want finish");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    logic [7:0] v;
    int         n;
    nreset      = 1'b1;
    pad_strobe  = 1'b0;
    pad_clk     = 1'b1;
    buttons_raw = 8'h00;
    mdl_strobe  = 1'b0;
    model_reset();
    tick(3);
    push_check("reset_state");
    nreset = 1'b0;
    tick(2);
    push_check("post_reset_idle");

    // fixed pattern, full read plus overrun
    hold_buttons(8'b1000_0101, "db_85");
    strobe_pulse(2);
    for (int i = 0; i < 8; i++) pad_clk_pulse(2, $sformatf("shift%0d", i + 1));
    for (int i = 0; i < 3; i++) pad_clk_pulse(1, "overrun");

    // bounce on Start must never be accepted, then a steady press after 4 cycles
    for (int k = 0; k < 10; k++) begin
      buttons_raw[3] = ~buttons_raw[3];
      tick(2);
      push_check("bounce");
    end
    tick(4);
    push_check("bounce_settled");
    buttons_raw[3] = 1'b1;
    tick(5);
    push_check("db3_before");
    tick(1);
    mdl_db[3] = 1'b1;
    push_check("db3_accept");
    tick(4);

    // clock held low has no effect
    pad_clk = 1'b0;
    tick(8);
    push_check("clk_held_low");
    pad_clk = 1'b1;
    tick(4);

    // strobe held high: clocks ignored, pad_data follows buttons
    strobe_set(1'b1);
    pad_clk_pulse(2, "clk_in_strobe");
    pad_clk_pulse(1, "clk_in_strobe");
    hold_buttons(8'b0101_1010, "track_db");
    hold_buttons(8'b0101_1011, "track_db");
    strobe_set(1'b0);
    for (int i = 0; i < 3; i++) pad_clk_pulse(2, "pre_restrobe");
    strobe_pulse(1);
    pad_clk_pulse(2, "after_restrobe");

    // reset mid-sequence, then recovery
    strobe_pulse(2);
    for (int i = 0; i < 4; i++) pad_clk_pulse(2, "pre_reset");
    do_reset();
    tick(1);
    push_check("reset_release");
    hold_buttons(8'b0101_1011, "db_after_reset");
    strobe_pulse(2);
    for (int i = 0; i < 9; i++) pad_clk_pulse(2, "resume");

    // buttons changed after strobe fall do not disturb latched bits
    hold_buttons(8'h3C, "pre_change");
    strobe_pulse(2);
    hold_buttons(8'hC3, "post_fall_change");
    for (int i = 0; i < 9; i++) pad_clk_pulse(1, "latched_shift");

    // randomized sessions
    for (int it = 0; it < 30; it++) begin
      v = 8'($urandom_range(0, 255));
      hold_buttons(v, "rnd_db");
      if ($urandom_range(0, 3) == 0) glitch(8'($urandom_range(1, 255)), $urandom_range(1, DB - 1));
      strobe_pulse($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) hold_buttons(8'($urandom_range(0, 255)), "rnd_change");
      n = $urandom_range(0, 11);
      for (int s = 0; s < n; s++) pad_clk_pulse($urandom_range(1, 3), "rnd_shift");
      if ($urandom_range(0, 5) == 0) do_reset();
    end

    tick(3);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
